ue1w_core: RTL and testbench
============================

# ue1w_core

Parametrised successor to the 1-bit UE-1 control unit: a WIDTH-bit result-register ICU executing the same 16-opcode instruction set, one instruction per accepted cycle. Sits behind the multi-project wrapper with the instruction nibble and data bus driven from pads. Adds an instruction-valid stall input, a registered data-out bus and a skip-pending mechanism that survives stalls.

## Interface
- WIDTH, 8, width of RR, data_in, data_out (legal 1..32)
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous reset, active-high (one clock; reset is synchronous and active-high)
- instr_valid  in  1  instr is present this cycle
- instr  in  4  opcode
- data_in  in  WIDTH  external data bus
- data_out  out  WIDTH  registered store data
- rr  out  WIDTH  result register
- car  out  1  carry register
- ien, oen  out  1  input / output enable registers
- write  out  1  store strobe
- ioc, rtn, nopo, nopf  out  1  one-cycle flag pulses
- skip  out  1  skip pending

## Operation
- Instruction accepted when instr_valid=1 and rst=0; effect visible after that rising edge.
- Gated input D = ien ? data_in : 0.
- Opcodes: 0 NOPO (nopo pulse); 1 LD RR<=D; 2 ADD {car,RR}<=RR+D+car; 3 SUB {car,RR}<=RR+~D+car (car=1 means no borrow); 4 ONE RR<=1, car<=0; 5 NAND RR<=~(RR&D); 6 OR RR<=RR|D; 7 XOR RR<=RR^D; 8 STO; 9 STOC; A IEN ien<=data_in[0]; B OEN oen<=data_in[0]; C IOC (ioc pulse); D RTN (rtn pulse, skip<=1); E SKZ skip<=(RR==0); F NOPF (nopf pulse).
- IEN/OEN sample ungated data_in[0] (otherwise ien=0 deadlocks).
- STO: if oen, data_out<=RR and write=1; STOC: if oen, data_out<=~RR, write=1; if oen=0, no change, no strobe.
- Only ADD/SUB/ONE alter car; logic ops leave car.
- Skip: while skip=1, next accepted instruction is discarded (no state change, no pulse, even RTN/SKZ) and skip clears; no chaining.

## Timing
- Reset values: rr=0, car=0, ien=0, oen=0, data_out=0, skip=0, all pulses 0.
- Latency 1 cycle, all outputs registered.
- Pulses (write, ioc, rtn, nopo, nopf) high exactly one cycle after acceptance; low during any cycle following a stall or discard.
- instr_valid=0: all registers hold, skip held, pulses drop.
- Back-to-back accepted instructions: full throughput, one per cycle; RR forwarding is inherent (single register).
- ADD/SUB wrap modulo 2^WIDTH, carry out to car.
- rst has priority over instr_valid; reset mid-skip clears skip.

## Configuration
- UE1W_SHIFT_EN defined: opcode 0 becomes SHL — {car,RR}<={RR,car} (rotate through carry) and still pulses nopo. Undefined: opcode 0 is pure NOPO, RR/car untouched.

## Structure
- Package ue1w_pkg: 4-bit opcode localparams (OP_NOPO..OP_NOPF).
- Sub-module ue1w_alu: combinational, takes op, RR, D, car; returns next RR, next car, rr_we, car_we. Core holds registers, skip and strobe logic.

## Test plan
- Reset, then IEN with data_in[0]=1, LD 0xA5 -> rr=0xA5, car=0, ien=1 one cycle after LD.
- rr=0xF0, car=0, ADD 0x20 -> rr=0x10, car=1; then SUB 0x10 with car=1 -> rr=0x00, car=1.
- oen=0, STO -> write stays 0, data_out unchanged; OEN(1), STOC with rr=0x0F -> data_out=0xF0, write high exactly one cycle.
- rr=0, SKZ, instr_valid low 3 cycles, then LD 0x55 -> skip stays 1 through stall, LD discarded, rr=0, skip clears; following LD 0x55 -> rr=0x55.
- RTN followed by SKZ with rr=0 -> rtn pulse, SKZ discarded, skip=0 after; IOC -> ioc single-cycle pulse.
- UE1W_SHIFT_EN: rr=0x81, car=0, opcode 0 -> rr=0x02, car=1, nopo pulse; without macro -> rr=0x81, car=0, nopo pulse.

Source files
------------

// File: rtl/ue1w_pkg.sv
// Shared opcode definitions for the ue1w result-register control unit.
package ue1w_pkg;

  localparam logic [3:0] OP_NOPO = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_ONE  = 4'h4;
  localparam logic [3:0] OP_NAND = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_STO  = 4'h8;
  localparam logic [3:0] OP_STOC = 4'h9;
  localparam logic [3:0] OP_IEN  = 4'hA;
  localparam logic [3:0] OP_OEN  = 4'hB;
  localparam logic [3:0] OP_IOC  = 4'hC;
  localparam logic [3:0] OP_RTN  = 4'hD;
  localparam logic [3:0] OP_SKZ  = 4'hE;
  localparam logic [3:0] OP_NOPF = 4'hF;

endpackage

// File: rtl/ue1w_alu.sv
// Combinational datapath for ue1w: next RR / carry and their write enables.
// With UE1W_SHIFT_EN defined, opcode 0 rotates {car,RR} left by one.
module ue1w_alu
  import ue1w_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rr,
  input  logic [WIDTH-1:0] d,
  input  logic             car,
  output logic [WIDTH-1:0] rr_next,
  output logic             car_next,
  output logic             rr_we,
  output logic             car_we
);

  logic [WIDTH:0] sum;

  always_comb begin
    rr_next  = rr;
    car_next = car;
    rr_we    = 1'b0;
    car_we   = 1'b0;
    sum      = '0;
    case (op)
`ifdef UE1W_SHIFT_EN
      OP_NOPO: begin
        sum      = {rr, car};
        rr_next  = sum[WIDTH-1:0];
        car_next = sum[WIDTH];
        rr_we    = 1'b1;
        car_we   = 1'b1;
      end
`endif
      OP_LD: begin
        rr_next = d;
        rr_we   = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        // SUB adds the one's complement so car=1 reads as "no borrow"
        sum      = {1'b0, rr} + {1'b0, (op == OP_SUB) ? ~d : d} + {{WIDTH{1'b0}}, car};
        rr_next  = sum[WIDTH-1:0];
        car_next = sum[WIDTH];
        rr_we    = 1'b1;
        car_we   = 1'b1;
      end
      OP_ONE: begin
        rr_next  = {{(WIDTH-1){1'b0}}, 1'b1};
        car_next = 1'b0;
        rr_we    = 1'b1;
        car_we   = 1'b1;
      end
      OP_NAND: begin
        rr_next = ~(rr & d);
        rr_we   = 1'b1;
      end
      OP_OR: begin
        rr_next = rr | d;
        rr_we   = 1'b1;
      end
      OP_XOR: begin
        rr_next = rr ^ d;
        rr_we   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ue1w_core.sv
// ue1w control unit: registers, enables, skip-pending and one-cycle strobes.
// Optional UE1W_SHIFT_EN turns opcode 0 into a rotate-through-carry.
module ue1w_core
  import ue1w_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [3:0]       instr,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rr,
  output logic             car,
  output logic             ien,
  output logic             oen,
  output logic             write,
  output logic             ioc,
  output logic             rtn,
  output logic             nopo,
  output logic             nopf,
  output logic             skip
);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] rr_next;
  logic             car_next;
  logic             rr_we;
  logic             car_we;

  assign d = ien ? data_in : '0;

  ue1w_alu #(.WIDTH(WIDTH)) u_alu (
    .op      (instr),
    .rr      (rr),
    .d       (d),
    .car     (car),
    .rr_next (rr_next),
    .car_next(car_next),
    .rr_we   (rr_we),
    .car_we  (car_we)
  );

  // A pending skip swallows exactly the next accepted instruction; stalls keep it pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr       <= '0;
      car      <= 1'b0;
      ien      <= 1'b0;
      oen      <= 1'b0;
      data_out <= '0;
      skip     <= 1'b0;
      write    <= 1'b0;
      ioc      <= 1'b0;
      rtn      <= 1'b0;
      nopo     <= 1'b0;
      nopf     <= 1'b0;
    end else begin
      write <= 1'b0;
      ioc   <= 1'b0;
      rtn   <= 1'b0;
      nopo  <= 1'b0;
      nopf  <= 1'b0;
      if (instr_valid) begin
        if (skip) begin
          skip <= 1'b0;
        end else begin
          if (rr_we)  rr  <= rr_next;
          if (car_we) car <= car_next;
          case (instr)
            OP_NOPO: nopo <= 1'b1;
            OP_STO: if (oen) begin
              data_out <= rr;
              write    <= 1'b1;
            end
            OP_STOC: if (oen) begin
              data_out <= ~rr;
              write    <= 1'b1;
            end
            OP_IEN:  ien  <= data_in[0];
            OP_OEN:  oen  <= data_in[0];
            OP_IOC:  ioc  <= 1'b1;
            OP_RTN: begin
              rtn  <= 1'b1;
              skip <= 1'b1;
            end
            OP_SKZ:  skip <= (rr == '0);
            OP_NOPF: nopf <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ue1w_core.sv
// Self-checking bench for ue1w_core: directed scenarios then randomized traffic
// against an arithmetic reference model.
module tb_ue1w_core;

  localparam int WIDTH = 8;
  localparam longint MASK = (64'd1 << WIDTH) - 1;

  logic             clk;
  logic             rst;
  logic             instr_valid;
  logic [3:0]       instr;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] rr;
  logic             car, ien, oen, write, ioc, rtn, nopo, nopf, skip;

  int total = 0;
  int bad = 0;

  longint m_rr, m_dout;
  bit m_car, m_ien, m_oen, m_skip;
  bit m_write, m_ioc, m_rtn, m_nopo, m_nopf;

  ue1w_core #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr      (instr),
    .data_in    (data_in),
    .data_out   (data_out),
    .rr         (rr),
    .car        (car),
    .ien        (ien),
    .oen        (oen),
    .write      (write),
    .ioc        (ioc),
    .rtn        (rtn),
    .nopo       (nopo),
    .nopf       (nopf),
    .skip       (skip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference behaviour of one clock edge, written from the instruction rules.
  task automatic modelStep(input bit r, input bit v, input int op, input longint din);
    longint dv, s;
    m_write = 0; m_ioc = 0; m_rtn = 0; m_nopo = 0; m_nopf = 0;
    if (r) begin
      m_rr = 0; m_car = 0; m_ien = 0; m_oen = 0; m_dout = 0; m_skip = 0;
    end else if (v) begin
      if (m_skip) m_skip = 0;
      else begin
        dv = m_ien ? din : 0;
        case (op)
          0: begin
`ifdef UE1W_SHIFT_EN
            s = m_rr * 2 + m_car;
            m_rr = s & MASK;
            m_car = (s >> WIDTH) & 1;
`endif
            m_nopo = 1;
          end
          1: m_rr = dv;
          2: begin s = m_rr + dv + m_car; m_rr = s & MASK; m_car = (s >> WIDTH) & 1; end
          3: begin s = m_rr + (MASK - dv) + m_car; m_rr = s & MASK; m_car = (s >> WIDTH) & 1; end
          4: begin m_rr = 1; m_car = 0; end
          5: m_rr = MASK - (m_rr & dv);
          6: m_rr = m_rr | dv;
          7: m_rr = m_rr ^ dv;
          8: if (m_oen) begin m_dout = m_rr; m_write = 1; end
          9: if (m_oen) begin m_dout = MASK - m_rr; m_write = 1; end
          10: m_ien = din & 1;
          11: m_oen = din & 1;
          12: m_ioc = 1;
          13: begin m_rtn = 1; m_skip = 1; end
          14: m_skip = (m_rr == 0);
          default: m_nopf = 1;
        endcase
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".rr"}, 32'(rr), 32'(m_rr));
    checkOutput({tag, ".car"}, 32'(car), 32'(m_car));
    checkOutput({tag, ".ien"}, 32'(ien), 32'(m_ien));
    checkOutput({tag, ".oen"}, 32'(oen), 32'(m_oen));
    checkOutput({tag, ".dout"}, 32'(data_out), 32'(m_dout));
    checkOutput({tag, ".skip"}, 32'(skip), 32'(m_skip));
    checkOutput({tag, ".pulses"}, {27'd0, write, ioc, rtn, nopo, nopf},
                {27'd0, m_write, m_ioc, m_rtn, m_nopo, m_nopf});
  endtask

  task automatic applyStimulus(input bit r, input bit v, input int op, input longint din, input string tag);
    @(negedge clk);
    rst = r; instr_valid = v; instr = 4'(op); data_in = WIDTH'(din);
    @(posedge clk);
    modelStep(r, v, op, din);
    #1;
    checkAll(tag);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = 4'h0; data_in = '0;
    applyStimulus(1, 0, 0, 0, "reset");
    checkOutput("reset.rr0", 32'(rr), 32'h0);

    applyStimulus(0, 1, 10, 1, "ien");
    applyStimulus(0, 1, 1, 'hA5, "ld_a5");
    checkOutput("ld_a5.rr", 32'(rr), 32'hA5);
    checkOutput("ld_a5.ien", 32'(ien), 32'h1);

    applyStimulus(0, 1, 4, 0, "one");
    applyStimulus(0, 1, 1, 'hF0, "ld_f0");
    applyStimulus(0, 1, 2, 'h20, "add");
    checkOutput("add.rr", 32'(rr), 32'h10);
    checkOutput("add.car", 32'(car), 32'h1);
    applyStimulus(0, 1, 3, 'h10, "sub");
    checkOutput("sub.rr", 32'(rr), 32'h00);
    checkOutput("sub.car", 32'(car), 32'h1);

    applyStimulus(0, 1, 8, 0, "sto_off");
    checkOutput("sto_off.write", 32'(write), 32'h0);
    applyStimulus(0, 1, 11, 1, "oen");
    applyStimulus(0, 1, 1, 'h0F, "ld_0f");
    applyStimulus(0, 1, 9, 0, "stoc");
    checkOutput("stoc.dout", 32'(data_out), 32'hF0);
    checkOutput("stoc.write", 32'(write), 32'h1);
    applyStimulus(0, 1, 15, 0, "after_stoc");
    checkOutput("after_stoc.write", 32'(write), 32'h0);

    applyStimulus(0, 1, 1, 0, "ld_0");
    applyStimulus(0, 1, 14, 0, "skz");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 'h55, "stall");
      checkOutput("stall.skip", 32'(skip), 32'h1);
    end
    applyStimulus(0, 1, 1, 'h55, "ld_skipped");
    checkOutput("ld_skipped.rr", 32'(rr), 32'h0);
    checkOutput("ld_skipped.skip", 32'(skip), 32'h0);
    applyStimulus(0, 1, 1, 'h55, "ld_55");
    checkOutput("ld_55.rr", 32'(rr), 32'h55);

    applyStimulus(0, 1, 1, 0, "ld_0b");
    applyStimulus(0, 1, 13, 0, "rtn");
    checkOutput("rtn.pulse", 32'(rtn), 32'h1);
    applyStimulus(0, 1, 14, 0, "skz_skipped");
    checkOutput("skz_skipped.skip", 32'(skip), 32'h0);
    applyStimulus(0, 1, 12, 0, "ioc");
    checkOutput("ioc.pulse", 32'(ioc), 32'h1);
    applyStimulus(0, 0, 12, 0, "ioc_drop");
    checkOutput("ioc_drop.pulse", 32'(ioc), 32'h0);

    applyStimulus(0, 1, 4, 0, "one_b");
    applyStimulus(0, 1, 1, 'h81, "ld_81");
    applyStimulus(0, 1, 0, 0, "op0");
`ifdef UE1W_SHIFT_EN
    checkOutput("shl.rr", 32'(rr), 32'h02);
    checkOutput("shl.car", 32'(car), 32'h1);
`else
    checkOutput("nopo.rr", 32'(rr), 32'h81);
    checkOutput("nopo.car", 32'(car), 32'h0);
`endif
    checkOutput("op0.nopo", 32'(nopo), 32'h1);

    applyStimulus(0, 1, 14, 0, "skz_nz");
    applyStimulus(1, 1, 13, 0, "rst_prio");

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(99) < 3, $urandom_range(99) < 80,
                    int'($urandom_range(15)), longint'($urandom) & MASK, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
